// File: rtl/mod_counter.sv
// Programmable up/down counter with run-time limit, wrap/one-shot mode,
// enable-gated prescaler, synchronous load and terminal-event outputs.
module mod_counter #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      max_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      q,
  output logic                  wrap,
  output logic                  done
);

  logic [PRESCALE_W-1:0] ps;
  logic                  tick;
  logic                  at_term;
  logic [WIDTH-1:0]      q_step;
  logic [WIDTH-1:0]      q_reload;

  // >= rather than == so lowering prescale below ps forces an immediate tick
  assign tick    = en && (ps >= prescale);
  // Up terminal uses >= so a value loaded above the limit still wraps
  assign at_term = dir ? (q >= max_val) : (q == '0);

  always_comb begin
    q_step   = q;
    q_reload = q;
    if (dir) begin
      q_step   = q + 1'b1;
      q_reload = '0;
    end else begin
      q_step   = q - 1'b1;
      q_reload = max_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      ps   <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      ps   <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        ps <= '0;
        if (!done) begin
          if (!at_term) begin
            q <= q_step;
          end else begin
            wrap <= 1'b1;
            if (mode) begin
              done <= 1'b1;
            end else begin
              q <= q_reload;
            end
          end
        end
      end else if (en) begin
        ps <= ps + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter using immediate assertions.
module tb_mod_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          load;
  logic [W-1:0]  load_val;
  logic          dir;
  logic          mode;
  logic [W-1:0]  max_val;
  logic [PW-1:0] prescale;
  logic [W-1:0]  q;
  logic          wrap;
  logic          done;

  int errors = 0;
  int checks = 0;

  mod_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .mode(mode), .max_val(max_val), .prescale(prescale),
    .q(q), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [W-1:0] eq, input logic ew, input logic ed);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    check({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; dir = 1'b1;
    mode = 1'b0; max_val = 8'd100; prescale = '0;
    #12;
    chk3("reset_init", 8'd0, 1'b0, 1'b0);
    rst = 1'b1;

    // Reset mid-count: reach 37, assert reset between edges
    do_load(8'd30);
    check("load30", 32'(q), 32'd30);
    en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk3("count37", 8'd37, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1 chk3("async_rst", 8'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk3("post_rst", 8'd1, 1'b0, 1'b0);

    // Up wrap, max_val=3
    max_val = 8'd3;
    do_load(8'd0);
    chk3("up_load0", 8'd0, 1'b0, 1'b0);
    step(); chk3("up1", 8'd1, 1'b0, 1'b0);
    step(); chk3("up2", 8'd2, 1'b0, 1'b0);
    step(); chk3("up3", 8'd3, 1'b0, 1'b0);
    step(); chk3("up_wrap0", 8'd0, 1'b1, 1'b0);
    step(); chk3("up1b", 8'd1, 1'b0, 1'b0);

    // Down wrap reloads max_val
    dir = 1'b0;
    do_load(8'd2);
    chk3("dn_load2", 8'd2, 1'b0, 1'b0);
    step(); chk3("dn1", 8'd1, 1'b0, 1'b0);
    step(); chk3("dn0", 8'd0, 1'b0, 1'b0);
    step(); chk3("dn_wrap3", 8'd3, 1'b1, 1'b0);
    step(); chk3("dn2", 8'd2, 1'b0, 1'b0);

    // Prescale=2 with enable gap
    dir = 1'b1; max_val = 8'd100; prescale = 4'd2;
    do_load(8'd0);
    step(); step(); check("ps_hold", 32'(q), 32'd0);
    step(); check("ps_tick1", 32'(q), 32'd1);
    step(); check("ps_mid", 32'(q), 32'd1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("en_off", 32'(q), 32'd1);
    en = 1'b1;
    step(); check("resume1", 32'(q), 32'd1);
    step(); check("resume_tick", 32'(q), 32'd2);

    // One-shot to max_val=5
    prescale = 4'd0; mode = 1'b1; max_val = 8'd5;
    do_load(8'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk3("os_cnt", 8'(i), 1'b0, 1'b0);
    end
    step(); chk3("os_term", 8'd5, 1'b1, 1'b1);
    step(); chk3("os_stop1", 8'd5, 1'b0, 1'b1);
    mode = 1'b0;
    step(); chk3("os_mode0_done", 8'd5, 1'b0, 1'b1);
    do_load(8'd0);
    chk3("os_reload", 8'd0, 1'b0, 1'b0);

    // Load beats tick in same cycle
    max_val = 8'd100;
    do_load(8'd4);
    check("ld_q4", 32'(q), 32'd4);
    do_load(8'd9);
    chk3("ld_over_tick", 8'd9, 1'b0, 1'b0);
    step(); check("ld_then10", 32'(q), 32'd10);
    max_val = 8'd10;
    do_load(8'd20);
    check("ld_above", 32'(q), 32'd20);
    step(); chk3("above_wrap", 8'd0, 1'b1, 1'b0);

    // Lowering prescale below ps forces a tick
    prescale = 4'd3;
    do_load(8'd0);
    step(); step(); check("ps_low_hold", 32'(q), 32'd0);
    prescale = 4'd1;
    step(); check("ps_low_tick", 32'(q), 32'd1);

    // max_val=0 wrap mode: wrap stays high, q stays 0
    prescale = 4'd0; max_val = 8'd0;
    do_load(8'd0);
    step(); chk3("mv0_a", 8'd0, 1'b1, 1'b0);
    step(); chk3("mv0_b", 8'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
